fifo_wr_bank_8: RTL

Write end of the 8-entry, single-clock FIFO used on the SIMD L0/OFIFO paths. Holds the 8 storage entries and the write pointer, and decodes each accepted push into exactly one entry. Exposes all entries in parallel so the read side's 8:1 mux selects with its own read pointer. Generates full/empty from its write pointer and the read side's pointer, and flags dropped pushes.

---
 rtl/fifo_wr_bank_8.sv | 89 ++++++++
 1 files changed

// File: rtl/fifo_wr_bank_8.sv
// Write side of an 8-entry single-clock FIFO: storage, write pointer, full/empty
// derivation against the read-side pointer, and a sticky overflow flag.
module fifo_wr_bank_8 #(
    parameter int unsigned bw   = 4,
    parameter int unsigned simd = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [simd*bw-1:0]   in,
    input  logic                 wr,
    input  logic [3:0]           rd_ptr,
    output logic [3:0]           wr_ptr,
    output logic [simd*bw-1:0]   q0,
    output logic [simd*bw-1:0]   q1,
    output logic [simd*bw-1:0]   q2,
    output logic [simd*bw-1:0]   q3,
    output logic [simd*bw-1:0]   q4,
    output logic [simd*bw-1:0]   q5,
    output logic [simd*bw-1:0]   q6,
    output logic [simd*bw-1:0]   q7,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_ovf
);

    localparam int unsigned W = simd * bw;

    logic [W-1:0] e_q [8];
    logic [W-1:0] e_d [8];
    logic [3:0]   wr_ptr_q, wr_ptr_d;
    logic         ovf_q, ovf_d;
    logic         full;
    logic         push_ok;

    // Full/empty from pointer comparison; bit 3 distinguishes full from empty.
    always_comb begin
        full    = (wr_ptr_q[2:0] == rd_ptr[2:0]) && (wr_ptr_q[3] != rd_ptr[3]);
        o_full  = full;
        o_empty = (wr_ptr_q == rd_ptr);
        push_ok = wr && !full;
    end

    // Next state: write exactly the addressed entry on an accepted push.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            e_d[i] = e_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            e_d[wr_ptr_q[2:0]] = in;
            wr_ptr_d           = wr_ptr_q + 4'd1;
        end else if (wr) begin
            ovf_d = 1'b1;
        end
    end

    // State registers with synchronous reset that overrides any push.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                e_q[i] <= '0;
            end
            wr_ptr_q <= 4'd0;
            ovf_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                e_q[i] <= e_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Outputs straight from the registers.
    always_comb begin
        wr_ptr = wr_ptr_q;
        o_ovf  = ovf_q;
        q0     = e_q[0];
        q1     = e_q[1];
        q2     = e_q[2];
        q3     = e_q[3];
        q4     = e_q[4];
        q5     = e_q[5];
        q6     = e_q[6];
        q7     = e_q[7];
    end

endmodule
